// File: rtl/sram_fifo_output_arbiter_if.sv
// Stream bundle for the SRAM-FIFO output arbiter: per-queue AXI4-Stream read
// sides on the s_* side, one merged AXI4-Stream on the m_* side.
interface sram_fifo_output_arbiter_if #(
  parameter int NUM_QUEUES     = 4,
  parameter int QUEUE_ID_WIDTH = 2,
  parameter int TDATA_WIDTH    = 32
) ();
  logic [NUM_QUEUES-1:0]               s_tvalid;
  logic [NUM_QUEUES-1:0]               s_tready;
  logic [NUM_QUEUES*8*TDATA_WIDTH-1:0] s_tdata;
  logic [NUM_QUEUES-1:0]               s_tlast;
  logic [NUM_QUEUES-1:0]               queue_en;
  logic                                m_tvalid;
  logic                                m_tready;
  logic [8*TDATA_WIDTH-1:0]            m_tdata;
  logic [TDATA_WIDTH-1:0]              m_tkeep;
  logic                                m_tlast;
  logic [QUEUE_ID_WIDTH-1:0]           m_tdest;

  // The arbiter itself uses master; the queues and the downstream sink use slave.
  modport master (
    input  s_tvalid, s_tdata, s_tlast, queue_en, m_tready,
    output s_tready, m_tvalid, m_tdata, m_tkeep, m_tlast, m_tdest
  );

  modport slave (
    output s_tvalid, s_tdata, s_tlast, queue_en, m_tready,
    input  s_tready, m_tvalid, m_tdata, m_tkeep, m_tlast, m_tdest
  );
endinterface

// File: rtl/sram_fifo_output_arbiter.sv
// Packet-level round-robin arbiter merging SRAM-FIFO read queues onto one
// AXI4-Stream output through a single registered output stage.
module sram_fifo_output_arbiter #(
  parameter int NUM_QUEUES     = 4,
  parameter int QUEUE_ID_WIDTH = 2,
  parameter int TDATA_WIDTH    = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  sram_fifo_output_arbiter_if.master bus,
  output logic [31:0]                pkt_cnt,
  output logic                       busy
);
  localparam int DW = 8 * TDATA_WIDTH;

  typedef enum logic {IDLE, SEND} state_t;

  state_t                    state_q, state_d;
  logic [QUEUE_ID_WIDTH-1:0] grant_q, grant_d;
  logic [QUEUE_ID_WIDTH-1:0] last_grant_q, last_grant_d;
  logic                      m_tvalid_q, m_tvalid_d;
  logic                      m_tlast_q, m_tlast_d;
  logic [DW-1:0]             m_tdata_q, m_tdata_d;
  logic [QUEUE_ID_WIDTH-1:0] m_tdest_q, m_tdest_d;
  logic [31:0]               pkt_cnt_q, pkt_cnt_d;

  logic [NUM_QUEUES-1:0]     eligible;
  logic [NUM_QUEUES-1:0]     s_tready;
  logic [QUEUE_ID_WIDTH-1:0] winner;
  logic [QUEUE_ID_WIDTH-1:0] cand;
  logic                      any_eligible;
  logic                      out_free;
  logic                      accept;
  logic                      accept_last;
  logic [DW-1:0]             grant_data;

  // Walk downwards from the farthest candidate so the queue closest after
  // last_grant is written last and wins.
  always_comb begin
    eligible     = bus.s_tvalid & bus.queue_en;
    winner       = grant_q;
    cand         = '0;
    any_eligible = 1'b0;
    for (int k = NUM_QUEUES; k >= 1; k--) begin
      cand = QUEUE_ID_WIDTH'((int'(last_grant_q) + k) % NUM_QUEUES);
      if (eligible[cand]) begin
        winner       = cand;
        any_eligible = 1'b1;
      end
    end
  end

  assign out_free = ~m_tvalid_q | bus.m_tready;

  always_comb begin
    s_tready = '0;
    for (int i = 0; i < NUM_QUEUES; i++) begin
      s_tready[i] = ~reset & (state_q == SEND) & out_free &
                    (grant_q == QUEUE_ID_WIDTH'(i));
    end
  end

  assign accept      = |(bus.s_tvalid & s_tready);
  assign accept_last = |(bus.s_tvalid & bus.s_tlast & s_tready);
  assign grant_data  = bus.s_tdata[int'(grant_q)*DW +: DW];

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    m_tvalid_d   = m_tvalid_q;
    m_tlast_d    = m_tlast_q;
    m_tdata_d    = m_tdata_q;
    m_tdest_d    = m_tdest_q;
    pkt_cnt_d    = pkt_cnt_q;

    case (state_q)
      IDLE: begin
        if (any_eligible) begin
          grant_d = winner;
          state_d = SEND;
        end
      end
      SEND: begin
        if (accept_last) begin
          state_d      = IDLE;
          last_grant_d = grant_q;
        end
      end
      default: state_d = IDLE;
    endcase

    // The payload only moves on an accepted beat, so backpressure freezes it.
    if (accept) begin
      m_tvalid_d = 1'b1;
      m_tdata_d  = grant_data;
      m_tlast_d  = accept_last;
      m_tdest_d  = grant_q;
    end else if (bus.m_tready) begin
      m_tvalid_d = 1'b0;
    end

    if (m_tvalid_q & bus.m_tready & m_tlast_q) begin
      pkt_cnt_d = pkt_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= QUEUE_ID_WIDTH'(NUM_QUEUES - 1);
      m_tvalid_q   <= 1'b0;
      m_tlast_q    <= 1'b0;
      m_tdata_q    <= '0;
      m_tdest_q    <= '0;
      pkt_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      m_tvalid_q   <= m_tvalid_d;
      m_tlast_q    <= m_tlast_d;
      m_tdata_q    <= m_tdata_d;
      m_tdest_q    <= m_tdest_d;
      pkt_cnt_q    <= pkt_cnt_d;
    end
  end

  assign bus.s_tready = s_tready;
  assign bus.m_tvalid = m_tvalid_q;
  assign bus.m_tdata  = m_tdata_q;
  assign bus.m_tkeep  = {TDATA_WIDTH{m_tvalid_q}};
  assign bus.m_tlast  = m_tlast_q;
  assign bus.m_tdest  = m_tdest_q;
  assign pkt_cnt      = pkt_cnt_q;
  assign busy         = (state_q == SEND);
endmodule

// File: tb/tb_sram_fifo_output_arbiter.sv
// Directed bench for sram_fifo_output_arbiter: simple per-queue packet sources,
// a log of beats taken on the output, and hand-computed expectations.
module tb_sram_fifo_output_arbiter;
  localparam int NQ = 4;
  localparam int QW = 2;
  localparam int TW = 4;
  localparam int DW = 8 * TW;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pkt_cnt;
  logic        busy;

  int checks = 0;
  int errors = 0;

  int pkts_left   [NQ];
  int pkt_len     [NQ];
  int beat_in_pkt [NQ];
  int beat_ctr    [NQ];
  bit hold        [NQ];

  logic [DW-1:0] log_data [64];
  logic [QW-1:0] log_dest [64];
  logic          log_last [64];
  int            log_n;
  logic          vhist    [64];
  int            cyc;
  bit            q0_ready_seen;

  sram_fifo_output_arbiter_if #(.NUM_QUEUES(NQ), .QUEUE_ID_WIDTH(QW), .TDATA_WIDTH(TW)) bus ();

  sram_fifo_output_arbiter #(.NUM_QUEUES(NQ), .QUEUE_ID_WIDTH(QW), .TDATA_WIDTH(TW)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .pkt_cnt (pkt_cnt),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // Beat payload: 0xC0DE in the top half, queue number, running beat number.
  function automatic logic [DW-1:0] beat_word(input int q, input int b);
    return DW'(32'hC0DE_0000 | (q << 8) | (b & 8'hFF));
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic drive_sources();
    for (int i = 0; i < NQ; i++) begin
      bus.s_tvalid[i]         = (pkts_left[i] > 0) && !hold[i];
      bus.s_tlast[i]          = (beat_in_pkt[i] == pkt_len[i] - 1);
      bus.s_tdata[i*DW +: DW] = beat_word(i, beat_ctr[i]);
    end
  endtask

  task automatic clear_sources();
    for (int i = 0; i < NQ; i++) begin
      pkts_left[i]   = 0;
      pkt_len[i]     = 1;
      beat_in_pkt[i] = 0;
      beat_ctr[i]    = 0;
      hold[i]        = 1'b0;
    end
    drive_sources();
  endtask

  task automatic load_queue(input int q, input int npkts, input int len);
    pkts_left[q]   = npkts;
    pkt_len[q]     = len;
    beat_in_pkt[q] = 0;
    drive_sources();
  endtask

  // One clock: sample handshakes at the falling edge, then advance the
  // sources past whatever the rising edge consumed.
  task automatic applyStimulus();
    bit fire [NQ];
    @(negedge clk);
    for (int i = 0; i < NQ; i++) fire[i] = bus.s_tvalid[i] && bus.s_tready[i];
    if (bus.s_tready[0]) q0_ready_seen = 1'b1;
    if (cyc < 64) vhist[cyc] = bus.m_tvalid;
    cyc++;
    if (bus.m_tvalid && bus.m_tready && log_n < 64) begin
      log_data[log_n] = bus.m_tdata;
      log_dest[log_n] = bus.m_tdest;
      log_last[log_n] = bus.m_tlast;
      log_n++;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NQ; i++) begin
      if (fire[i]) begin
        beat_ctr[i]++;
        beat_in_pkt[i]++;
        if (beat_in_pkt[i] == pkt_len[i]) begin
          beat_in_pkt[i] = 0;
          pkts_left[i]--;
        end
      end
    end
    drive_sources();
  endtask

  task automatic start_scenario();
    log_n         = 0;
    cyc           = 0;
    q0_ready_seen = 1'b0;
  endtask

  task automatic reset_dut();
    clear_sources();
    reset = 1'b1;
    applyStimulus();
    applyStimulus();
    reset = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    bus.m_tready = 1'b1;
    bus.queue_en = 4'hF;
    log_n        = 0;
    cyc          = 0;
    clear_sources();

    reset_dut();
    checkOutput("rst_m_tvalid", bus.m_tvalid, 0);
    checkOutput("rst_m_tlast", bus.m_tlast, 0);
    checkOutput("rst_m_tdata", bus.m_tdata, 0);
    checkOutput("rst_m_tdest", bus.m_tdest, 0);
    checkOutput("rst_pkt_cnt", pkt_cnt, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_s_tready", bus.s_tready, 0);

    // Queues 0 and 2 each offer one 3-beat packet.
    start_scenario();
    load_queue(0, 1, 3);
    load_queue(2, 1, 3);
    applyStimulus();
    checkOutput("s1_busy", busy, 1);
    checkOutput("s1_s_tready", bus.s_tready, 4'b0001);
    checkOutput("s1_first_tvalid", bus.m_tvalid, 0);
    applyStimulus();
    checkOutput("s1_latency_tvalid", bus.m_tvalid, 1);
    checkOutput("s1_latency_tdata", bus.m_tdata, 32'hC0DE_0000);
    checkOutput("s1_latency_tdest", bus.m_tdest, 0);
    checkOutput("s1_tkeep", bus.m_tkeep, 4'hF);
    repeat (3) applyStimulus();
    checkOutput("s1_gap_tvalid", bus.m_tvalid, 0);
    checkOutput("s1_gap_busy", busy, 1);
    repeat (6) applyStimulus();
    checkOutput("s1_pkt_cnt", pkt_cnt, 2);
    checkOutput("s1_log_n", log_n, 6);
    for (int i = 0; i < 6; i++) begin
      checkOutput($sformatf("s1_data%0d", i), log_data[i], beat_word((i < 3) ? 0 : 2, i % 3));
      checkOutput($sformatf("s1_dest%0d", i), log_dest[i], (i < 3) ? 0 : 2);
      checkOutput($sformatf("s1_last%0d", i), log_last[i], (i % 3) == 2);
    end

    // Every queue always has a single-beat packet waiting.
    reset_dut();
    start_scenario();
    for (int q = 0; q < NQ; q++) load_queue(q, 50, 1);
    repeat (20) applyStimulus();
    for (int k = 0; k < 12; k++) begin
      checkOutput($sformatf("s2_valid_c%0d", 2 + k), vhist[2 + k], (k % 2) == 0);
    end
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("s2_dest%0d", i), log_dest[i], i % 4);
      checkOutput($sformatf("s2_data%0d", i), log_data[i], beat_word(i % 4, i / 4));
    end

    // Queue 1 4-beat packet, sink stalls for 5 cycles while beat 2 is shown.
    reset_dut();
    start_scenario();
    load_queue(1, 1, 4);
    repeat (4) applyStimulus();
    checkOutput("s3_beat2", bus.m_tdata, 32'hC0DE_0102);
    bus.m_tready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      applyStimulus();
      checkOutput($sformatf("s3_hold_data%0d", k), bus.m_tdata, 32'hC0DE_0102);
      checkOutput($sformatf("s3_hold_valid%0d", k), bus.m_tvalid, 1);
      checkOutput($sformatf("s3_hold_s_tready%0d", k), bus.s_tready, 0);
    end
    bus.m_tready = 1'b1;
    repeat (4) applyStimulus();
    checkOutput("s3_log_n", log_n, 4);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("s3_data%0d", i), log_data[i], beat_word(1, i));
      checkOutput($sformatf("s3_last%0d", i), log_last[i], i == 3);
    end
    checkOutput("s3_pkt_cnt", pkt_cnt, 1);

    // Queue 0 disabled; queue 1 loses its enable and valid mid-packet.
    reset_dut();
    start_scenario();
    bus.queue_en = 4'b1110;
    load_queue(0, 1, 2);
    load_queue(1, 1, 4);
    load_queue(2, 1, 1);
    repeat (2) applyStimulus();
    bus.queue_en = 4'b1100;
    hold[1] = 1'b1;
    drive_sources();
    for (int k = 0; k < 2; k++) begin
      applyStimulus();
      checkOutput($sformatf("s4_busy_hold%0d", k), busy, 1);
      checkOutput($sformatf("s4_hold_s_tready%0d", k), bus.s_tready, 4'b0010);
    end
    hold[1] = 1'b0;
    drive_sources();
    repeat (12) applyStimulus();
    checkOutput("s4_log_n", log_n, 5);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("s4_dest%0d", i), log_dest[i], 1);
      checkOutput($sformatf("s4_data%0d", i), log_data[i], beat_word(1, i));
    end
    checkOutput("s4_dest4", log_dest[4], 2);
    checkOutput("s4_data4", log_data[4], beat_word(2, 0));
    checkOutput("s4_q0_never_ready", q0_ready_seen, 0);
    checkOutput("s4_pkt_cnt", pkt_cnt, 2);
    checkOutput("s4_idle", busy, 0);

    // Reset pulse while beat 2 of a queue 1 packet sits on the output.
    start_scenario();
    clear_sources();
    bus.queue_en = 4'hF;
    load_queue(1, 1, 4);
    repeat (4) applyStimulus();
    checkOutput("s5_beat2", bus.m_tdata, 32'hC0DE_0102);
    reset = 1'b1;
    clear_sources();
    load_queue(0, 1, 1);
    load_queue(2, 1, 1);
    applyStimulus();
    reset = 1'b0;
    checkOutput("s5_rst_tvalid", bus.m_tvalid, 0);
    checkOutput("s5_rst_pkt_cnt", pkt_cnt, 0);
    checkOutput("s5_rst_busy", busy, 0);
    checkOutput("s5_rst_s_tready", bus.s_tready, 0);
    log_n = 0;
    repeat (8) applyStimulus();
    checkOutput("s5_log_n", log_n, 2);
    checkOutput("s5_first_dest", log_dest[0], 0);
    checkOutput("s5_second_dest", log_dest[1], 2);
    checkOutput("s5_pkt_cnt", pkt_cnt, 2);

    // Packet counter preloaded just below wrap, then two packets.
    reset_dut();
    start_scenario();
    force dut.pkt_cnt_q = 32'hFFFF_FFFE;
    applyStimulus();
    release dut.pkt_cnt_q;
    checkOutput("s6_preload_hold", pkt_cnt, 32'hFFFF_FFFE);
    load_queue(0, 1, 1);
    load_queue(3, 1, 1);
    repeat (8) applyStimulus();
    checkOutput("s6_log_n", log_n, 2);
    checkOutput("s6_wrap", pkt_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sram_fifo_output_arbiter.md
SRAM_FIFO_OUTPUT_ARBITER -- requirements
Module: sram_fifo_output_arbiter

Interface
REQ-001 Parameter NUM_QUEUES, default 4: number of SRAM-FIFO read-side AXI4-Stream sources.
REQ-002 Parameter QUEUE_ID_WIDTH, default 2: width of the queue index; SHALL satisfy 2^QUEUE_ID_WIDTH >= NUM_QUEUES.
REQ-003 Parameter TDATA_WIDTH, default 32: bus width in bytes, so data is 8*TDATA_WIDTH bits.
REQ-004 Port clk, input, 1: clock; reset, input, 1: reset, synchronous, active-high.
REQ-005 Port s_tvalid, input, NUM_QUEUES: per-queue valid.
REQ-006 Port s_tready, output, NUM_QUEUES: per-queue ready.
REQ-007 Port s_tdata, input, NUM_QUEUES*8*TDATA_WIDTH: per-queue data; queue i occupies slice i.
REQ-008 Port s_tlast, input, NUM_QUEUES: per-queue end of packet.
REQ-009 Port queue_en, input, NUM_QUEUES: per-queue arbitration enable.
REQ-010 Port m_tvalid, output, 1: output valid.
REQ-011 Port m_tready, input, 1: output ready.
REQ-012 Port m_tdata, output, 8*TDATA_WIDTH: output data.
REQ-013 Port m_tkeep, output, TDATA_WIDTH: output byte keep.
REQ-014 Port m_tlast, output, 1: output end of packet.
REQ-015 Port m_tdest, output, QUEUE_ID_WIDTH: source queue of the current beat.
REQ-016 Port pkt_cnt, output, 32: count of packets completed on the output.
REQ-017 Port busy, output, 1: high while the FSM is in SEND.

Function
REQ-018 The FSM SHALL have exactly two states, IDLE and SEND, held in a register.
REQ-019 IDLE arbitration: round-robin over requesters with s_tvalid[i] & queue_en[i], searching from last_grant+1 upward with wrap modulo NUM_QUEUES.
REQ-020 In IDLE with at least one eligible requester, the winner SHALL be registered into grant at the next edge, and the FSM SHALL move to SEND.
REQ-021 In IDLE with no eligible requester, the FSM SHALL remain in IDLE, and grant and last_grant SHALL hold.
REQ-022 s_tready[i] = (state==SEND) & (grant==i) & (~m_tvalid | m_tready); all other bits SHALL be 0.
REQ-023 Output register: on the accepted beat s_tvalid[grant] & s_tready[grant], load m_tdata, m_tlast and m_tdest=grant, and set m_tvalid=1.
REQ-024 Otherwise, if m_tready is high, clear m_tvalid.
REQ-025 Otherwise, hold m_tvalid and the output payload unchanged while m_tvalid & ~m_tready (no payload change under backpressure).
REQ-026 Latency: an accepted source beat SHALL appear on m_* exactly 1 cycle later; full throughput of 1 beat/cycle SHALL be sustained within a packet when m_tready stays high.
REQ-027 When a beat with s_tlast[grant]=1 is accepted, the FSM SHALL return to IDLE and last_grant SHALL be set to grant.
REQ-028 Packet boundary gap: exactly one IDLE cycle SHALL separate consecutive packets.
REQ-029 A grant SHALL be held until tlast; deasserting queue_en[grant] or s_tvalid[grant] mid-packet SHALL stall and SHALL NOT abort or switch the packet.
REQ-030 m_tkeep SHALL be all ones whenever m_tvalid=1.
REQ-031 pkt_cnt SHALL increment by 1 on each m_tvalid & m_tready & m_tlast, and SHALL wrap from 0xFFFFFFFF to 0.
REQ-032 A single-beat packet (first beat carries tlast) SHALL be valid: IDLE -> SEND -> IDLE.
REQ-033 A grant index >= NUM_QUEUES SHALL be unreachable.

Reset
REQ-034 On reset the block SHALL set state=IDLE, grant=0, and last_grant=NUM_QUEUES-1, so that queue 0 has first priority.
REQ-035 On reset the block SHALL set m_tvalid=0, m_tlast=0, m_tdata=0, m_tdest=0, pkt_cnt=0, and s_tready=0.
REQ-036 Reset asserted mid-packet SHALL discard the in-flight packet and output beat, with no partial recovery after release.

Verification
REQ-037 Reset, then queues 0 and 2 each hold a 3-beat packet, queue_en=4'hF, m_tready=1 -> output is q0 beats (m_tdest=0), one gap cycle, then q2 beats (m_tdest=2); pkt_cnt=2.
REQ-038 All 4 queues continuously valid with 1-beat packets -> m_tdest sequence 0,1,2,3,0,... and every second cycle has m_tvalid=1.
REQ-039 q1 4-beat packet with m_tready low for 5 cycles on beat 2 -> m_tdata holds beat 2, s_tready[1]=0 during the stall, and no beat is lost or duplicated.
REQ-040 queue_en=4'b1110 with q0 and q1 valid -> q0 never granted; clearing queue_en[1] mid q1 packet -> packet completes.
REQ-041 Reset pulse during beat 2 of a 4-beat packet -> next cycle m_tvalid=0, pkt_cnt=0, state IDLE, and q0 has priority.
REQ-042 Preload pkt_cnt near wrap (force to 0xFFFFFFFE), then send 2 packets -> pkt_cnt reads 0.
